// File: rtl/mw_add_seq_if.sv
// Operand/result stream bundle for the multi-word add sequencer.
// Slave side is the sequencer; master side is the producer/consumer pair.
interface mw_add_seq_if #(
    parameter int MAX_WORDS = 8
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic          in_cin;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;
    logic [CW-1:0] out_beats;
    logic          err;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf,
               out_beats, err
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf,
               out_beats, err
    );
endinterface

// File: rtl/mw_add_seq.sv
// Multi-word adder sequencer: chains carry across 32-bit beats through one ripple adder.
// Latency: 1 cycle (registered result). Backpressure: in_ready = !out_valid || out_ready.
// Upstream must hold a beat stable while in_ready is low; carry/state hold while stalled.

module Full_32bit_Adder (
    output logic [31:0] sum,
    output logic        ca,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);
    logic [32:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign ca = c[32];
endmodule

module mw_add_seq #(
    parameter int MAX_WORDS = 8
) (
    input  logic             clk,
    input  logic             rst,
    mw_add_seq_if.slave      bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          vld_q, vld_d;
    logic [31:0]   sum_q, sum_d;
    logic          last_q, last_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] beats_q, beats_d;
    logic          err_q, err_d;

    logic          accept;
    logic          add_cin;
    logic [31:0]   add_sum;
    logic          add_ca;
    logic          c31;
    logic          ovf;
    logic          err_beat;
    logic [CW-1:0] cnt_nxt;

    assign bus.in_ready = !vld_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign add_cin      = (state_q == IDLE) ? bus.in_cin : c_q;

    Full_32bit_Adder u_add (
        .sum (add_sum),
        .ca  (add_ca),
        .a   (bus.in_a),
        .b   (bus.in_b),
        .cin (add_cin)
    );

    // The adder hides its internal carries; recover carry into bit 31 from the sum bit.
    assign c31      = bus.in_a[31] ^ bus.in_b[31] ^ add_sum[31];
    assign ovf      = c31 ^ add_ca;
    assign cnt_nxt  = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
    assign err_beat = (state_q == RUN) && (cnt_q == CW'(MAX_WORDS)) && !bus.in_last;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        beats_d = beats_q;
        err_d   = err_q;

        if (accept) begin
            c_d     = add_ca;
            cnt_d   = cnt_nxt;
            vld_d   = 1'b1;
            sum_d   = add_sum;
            last_d  = bus.in_last;
            cout_d  = add_ca & bus.in_last;
            ovf_d   = ovf & bus.in_last;
            beats_d = bus.in_last ? cnt_nxt : '0;

            if (err_beat) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (bus.in_last) begin
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
        end else if (bus.out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_last  = last_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_beats = beats_q;
    assign bus.err       = err_q;
endmodule
